// File: rtl/gate_alu_pkg.sv
// gate_alu_pkg: shared op/state encodings and the bitwise op function
package gate_alu_pkg;
  localparam int MAXW = 64;
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;
  // Operands are carried at MAXW bits; callers truncate to their own width.
  function automatic logic [MAXW-1:0] apply_op(op_e o, logic [MAXW-1:0] x, logic [MAXW-1:0] z);
    logic [MAXW-1:0] r;
    case (o)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      OP_NAND: r = ~(x & z);
      OP_NOR:  r = ~(x | z);
      OP_XNOR: r = ~(x ^ z);
      OP_ANDN: r = x & ~z;
      default: r = x;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/gate_alu_pipe_op.sv
// gate_op_bitwise: combinational WIDTH-bit bitwise op unit
module gate_op_bitwise
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] r
);
  assign r = WIDTH'(apply_op(op_e'(op), MAXW'(x), MAXW'(z)));
endmodule

// File: rtl/gate_alu_pipe.sv
// gate_alu_pipe: registered bitwise ALU with element and burst-reduce modes
module gate_alu_pipe
  import gate_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_BEATS = 16,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CW-1:0]    out_count,
  output logic             overflow
);
  state_e state, state_n;
  logic [2:0] op_l, op_n, op_sel;
  logic mode_l, mode_n, fold, accept, emit;
  logic [WIDTH-1:0] acc, acc_n, y_n, x_sel, z_sel, r;
  logic [CW-1:0] cnt, cnt_n, cnt_inc, count_n;
  logic ovf_n, valid_n;

  // Inside a burst the op folds the accumulator with a; otherwise it combines a with b.
  assign fold    = mode_l & (state == ACCUM);
  assign op_sel  = fold ? op_l : op;
  assign x_sel   = fold ? acc : a;
  assign z_sel   = fold ? a : b;
  assign in_ready = (state == IDLE) ? (~out_valid | out_ready) : (state != EMIT);
  assign accept  = in_valid & in_ready;
  assign emit    = out_valid & out_ready;
  assign cnt_inc = cnt + CW'(1);

  gate_op_bitwise #(.WIDTH(WIDTH)) u_op (
    .op(op_sel),
    .x (x_sel),
    .z (z_sel),
    .r (r)
  );

  // Next-state and next-output logic; the result is loaded into y the cycle a burst completes.
  always_comb begin
    state_n = state;
    op_n    = op_l;
    mode_n  = mode_l;
    acc_n   = acc;
    cnt_n   = cnt;
    y_n     = y;
    count_n = out_count;
    ovf_n   = overflow;
    valid_n = out_valid;
    case (state)
      IDLE: begin
        if (emit) valid_n = 1'b0;
        if (accept && !mode) begin
          y_n     = r;
          count_n = CW'(1);
          ovf_n   = 1'b0;
          valid_n = 1'b1;
        end
        if (accept && mode) begin
          op_n   = op;
          mode_n = 1'b1;
          acc_n  = r;
          cnt_n  = CW'(1);
          if (in_last || MAX_BEATS == 1) begin
            state_n = EMIT;
            y_n     = r;
            count_n = CW'(1);
            ovf_n   = ~in_last;
            valid_n = 1'b1;
          end else begin
            state_n = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_n = r;
          cnt_n = cnt_inc;
          if (in_last || cnt_inc == CW'(MAX_BEATS)) begin
            state_n = EMIT;
            y_n     = r;
            count_n = cnt_inc;
            ovf_n   = ~in_last;
            valid_n = 1'b1;
          end
        end
      end
      EMIT: begin
        if (emit) begin
          valid_n = 1'b0;
          state_n = overflow ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (accept && in_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_l      <= 3'd0;
      mode_l    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      y         <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      op_l      <= op_n;
      mode_l    <= mode_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      y         <= y_n;
      out_count <= count_n;
      overflow  <= ovf_n;
      out_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_gate_alu_pipe.sv
// tb_gate_alu_pipe: table and scoreboard bench for gate_alu_pipe
module tb_gate_alu_pipe;
  localparam int W = 8;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0] op = 3'd0;
  logic mode = 1'b0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] y;
  logic [CW-1:0] out_count;
  logic overflow;

  typedef struct {logic [W-1:0] y; logic [CW-1:0] cnt; logic ovf;} exp_t;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [2:0] op; logic [W-1:0] y;} vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int emits = 0;
  int c0;

  gate_alu_pipe #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .op(op),
    .mode(mode),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .out_count(out_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, want, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] ey, input int c, input logic o);
    exp_t e;
    e.y = ey;
    e.cnt = CW'(c);
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic beat(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [2:0] to,
                      input logic tm, input logic tl);
    bit ok;
    ok = 1'b0;
    a = ta;
    b = tb2;
    op = to;
    mode = tm;
    in_last = tl;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      emits <= emits + 1;
      if (sb.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        e = sb.pop_front();
        chk("y", y, e.y);
        chk("out_count", out_count, e.cnt);
        chk("overflow", overflow, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30};
    tbl[1] = '{8'hF0, 8'h3C, 3'd1, 8'hFC};
    tbl[2] = '{8'hF0, 8'h3C, 3'd2, 8'hCC};
    tbl[3] = '{8'hF0, 8'h3C, 3'd3, 8'hCF};
    tbl[4] = '{8'hF0, 8'h3C, 3'd4, 8'h03};
    tbl[5] = '{8'hF0, 8'h3C, 3'd5, 8'h33};
    tbl[6] = '{8'hF0, 8'h3C, 3'd6, 8'hC0};
    tbl[7] = '{8'hF0, 8'h3C, 3'd7, 8'hF0};
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_count", out_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      push(tbl[i].y, 1, 1'b0);
      beat(tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, 1'b1);
    end
    chk("throughput_cycles", cyc - c0, 8);
    drain();
    out_ready = 1'b0;
    push(8'hF0, 1, 1'b0);
    push(8'hFF, 1, 1'b0);
    fork
      begin
        beat(8'h0F, 8'hFF, 3'd2, 1'b0, 1'b0);
        beat(8'h55, 8'hAA, 3'd2, 1'b0, 1'b0);
      end
    join_none
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_y_hold", y, 8'hF0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait fork;
    drain();
    push(8'h1F, 4, 1'b0);
    beat(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
    beat(8'h04, 8'h33, 3'd0, 1'b0, 1'b0);
    beat(8'h08, 8'h77, 3'd5, 1'b1, 1'b0);
    beat(8'h10, 8'h00, 3'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("reduce_latency", out_valid, 1);
    drain();
    push(8'h0F, 4, 1'b1);
    beat(8'h01, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h02, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h04, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h08, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h10, 8'h00, 3'd1, 1'b1, 1'b0);
    beat(8'h20, 8'h00, 3'd1, 1'b1, 1'b1);
    push(8'h0F, 1, 1'b0);
    beat(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b1);
    drain();
    push(8'hF0, 1, 1'b0);
    beat(8'hFF, 8'h0F, 3'd3, 1'b1, 1'b1);
    drain();
    beat(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
    beat(8'hAA, 8'h00, 3'd0, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", y, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(8'h0C, 2, 1'b0);
    beat(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
    beat(8'h3C, 8'h00, 3'd0, 1'b1, 1'b1);
    drain();
    out_ready = 1'b0;
    beat(8'hF0, 8'h3C, 3'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("held_out_valid", out_valid, 1);
    chk("held_y", y, 8'hFC);
    chk("held_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("emitrst_out_valid", out_valid, 0);
    chk("emitrst_y", y, 0);
    chk("emitrst_count", out_count, 0);
    chk("emitrst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("total_emits", emits, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/gate_alu_pipe.md
Name: gate_alu_pipe

Overview:
- Parametrised, registered successor of the two-input gate exercise.
- Applies one of eight bitwise logic ops to WIDTH-bit operands, with valid/ready handshakes on input and output.
- Element mode returns one result per beat.
- Reduce mode folds a burst of beats into one result, with beat count and an overflow flag.
- Sits between a stimulus source (switch/bench driver) and a display/sink stage.

Parameters:
- WIDTH, 8, operand and result width in bits.
- MAX_BEATS, 16, maximum beats folded in one reduce burst (>=1).
- CW, $clog2(MAX_BEATS+1), width of the beat counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  op select, sampled on first beat of each burst/beat.
- mode  in  1  0 = element, 1 = reduce; sampled with op.
- in_last  in  1  final beat of reduce burst; ignored in element mode.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts result.
- y  out  WIDTH  result.
- out_count  out  CW  beats folded into y (1 in element mode).
- overflow  out  1  reduce burst truncated at MAX_BEATS.

Behaviour:
- Single clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, y=0, out_count=0, overflow=0, state=IDLE, accumulator=0, latched op/mode=0. in_ready=1 in IDLE.
- Op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 A&~B, 7 PASS A. Pure bitwise, no carries; y is always exactly WIDTH bits.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- State machine states: IDLE, ACCUM, EMIT, DRAIN.
- IDLE, in_ready = ~out_valid | out_ready:
  - Element mode: on accept, y<=f(op,a,b), out_count<=1, overflow<=0, out_valid<=1 next cycle (1-cycle latency); stays IDLE. Back-to-back accept + emit in the same cycle allowed (full throughput).
  - Reduce mode: on accept, latch op/mode, acc<=f(op,a,b), cnt<=1.
    - in_last=1 or MAX_BEATS=1 -> EMIT.
    - Otherwise -> ACCUM.
  - Reduce accept requires no pending output.
- ACCUM, in_ready=1: each accepted beat does acc<=f(op_l,acc,a) (b ignored after first beat), cnt<=cnt+1.
  - in_last -> EMIT, overflow=0.
  - Else if cnt+1==MAX_BEATS -> EMIT with overflow=1, then DRAIN.
  - op/mode inputs ignored inside a burst.
- EMIT: out_valid=1, y=acc, out_count=cnt, in_ready=0. On emit -> IDLE, or -> DRAIN if overflow and the last beat has not been seen.
- DRAIN: in_ready=1; accepted beats discarded; accept with in_last -> IDLE. No output produced.
- Outputs y/out_count/overflow hold stable while out_valid & ~out_ready.
- Reset asserted mid-operation: all state and outputs return to reset values immediately, with no partial result emitted. The next burst starts clean.
- in_valid deasserted mid-burst: accumulator holds; no timeout.

Decomposition:
- Package gate_alu_pkg holds:
  - op_e enum (3-bit, encodings above).
  - state_e enum (IDLE, ACCUM, EMIT, DRAIN).
  - Function apply_op(op, x, z) returning WIDTH-bit result (parametrised via package function or macro width).
- One combinational sub-module, gate_op_bitwise (WIDTH param; ports op, x, z, r), instantiated once. Top holds handshake, FSM and registers.

Test Plan (WIDTH=8 unless noted):
- Element AND: a=F0, b=3C, op=0, out_ready=1 -> y=30, out_count=1, overflow=0, one cycle after accept; 4 consecutive beats give 4 results, no bubbles.
- Backpressure: out_ready=0 for 3 cycles with two element beats (XOR 0F^FF, 55^AA) -> in_ready=0 after first accept, y holds F0; after release, second yields FF; no loss or duplication.
- Reduce XOR, 4 beats: (a=01, b=02), a=04, a=08, a=10 with last -> y=1F, out_count=4, overflow=0, out_valid one cycle after last accept.
- Overflow, MAX_BEATS=4: reduce OR with a=01 (b=00), 02, 04, 08, 10, 20, last on sixth -> y=0F, out_count=4, overflow=1; beats 5-6 accepted and dropped; next burst AND FF&0F -> y=0F, count=1, overflow=0.
- Reset mid-burst: rst_n low two beats into ACCUM, asynchronous to clk -> out_valid=0, y=0, in_ready=1 without a clock edge; subsequent burst result is correct.
- Single-beat reduce: NAND a=FF, b=0F, in_last=1 on first beat -> y=F0, out_count=1, overflow=0.
